// File: rtl/yc_noc_defs_pkg.sv
// Shared NoC flit format and field helpers for the mesh network interface.
package yc_noc_defs;

    localparam int COORD_W   = 3;
    localparam int PAYLOAD_W = 16;

    typedef struct packed {
        logic [COORD_W-1:0]   dst_x;
        logic [COORD_W-1:0]   dst_y;
        logic [COORD_W-1:0]   src_x;
        logic [COORD_W-1:0]   src_y;
        logic [PAYLOAD_W-1:0] payload;
    } flit_t;

    localparam int FLIT_W = $bits(flit_t);

    function automatic logic [COORD_W-1:0] get_dst_x(input flit_t f);
        return f.dst_x;
    endfunction

    function automatic logic [COORD_W-1:0] get_dst_y(input flit_t f);
        return f.dst_y;
    endfunction

    function automatic logic [COORD_W-1:0] get_src_x(input flit_t f);
        return f.src_x;
    endfunction

    function automatic logic [COORD_W-1:0] get_src_y(input flit_t f);
        return f.src_y;
    endfunction

    function automatic logic [PAYLOAD_W-1:0] get_payload(input flit_t f);
        return f.payload;
    endfunction

    function automatic flit_t make_flit(
        input logic [COORD_W-1:0]   dx,
        input logic [COORD_W-1:0]   dy,
        input logic [COORD_W-1:0]   sx,
        input logic [COORD_W-1:0]   sy,
        input logic [PAYLOAD_W-1:0] data
    );
        flit_t f;
        f.dst_x   = dx;
        f.dst_y   = dy;
        f.src_x   = sx;
        f.src_y   = sy;
        f.payload = data;
        return f;
    endfunction

endpackage

// File: rtl/yc_noc_fifo.sv
// Registered FIFO with occupancy count; the extra count bit separates full from empty.
module yc_noc_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    output logic [W-1:0]           head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage needs no reset: entries are only visible once count covers them.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/yc_noc_ni.sv
// Mesh node network interface: packs core requests into flits for the router L port
// and delivers correctly addressed ejected flits back to the core.
module yc_noc_ni
    import yc_noc_defs::*;
#(
    parameter int X_ID     = 0,
    parameter int Y_ID     = 0,
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      tx_valid,
    output logic                      tx_ready,
    input  logic [COORD_W-1:0]        tx_dst_x,
    input  logic [COORD_W-1:0]        tx_dst_y,
    input  logic [PAYLOAD_W-1:0]      tx_data,
    output logic                      inj_valid,
    output logic [FLIT_W-1:0]         inj_flit,
    input  logic                      inj_ready,
    input  logic                      ej_valid,
    input  logic [FLIT_W-1:0]         ej_flit,
    output logic                      ej_ready,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    output logic [COORD_W-1:0]        rx_src_x,
    output logic [COORD_W-1:0]        rx_src_y,
    output logic [PAYLOAD_W-1:0]      rx_data,
    output logic [$clog2(TX_DEPTH):0] tx_count,
    output logic [$clog2(RX_DEPTH):0] rx_count,
    output logic [15:0]               misroute_cnt,
    output logic                      err_misroute
);
    localparam int RX_W = 2*COORD_W + PAYLOAD_W;
    localparam logic [COORD_W-1:0] MY_X = COORD_W'(X_ID);
    localparam logic [COORD_W-1:0] MY_Y = COORD_W'(Y_ID);

    logic              tx_full, tx_empty, tx_push, tx_pop;
    logic              rx_full, rx_empty, rx_push, rx_pop;
    logic              ej_take, addr_ok;
    flit_t             tx_flit, ej_f;
    logic [RX_W-1:0]   rx_entry, rx_head;

    // Handshakes are gated by rst_n so nothing completes in a reset cycle.
    assign tx_ready  = rst_n && !tx_full;
    assign tx_push   = tx_valid && tx_ready;
    assign inj_valid = rst_n && !tx_empty;
    assign tx_pop    = inj_valid && inj_ready;
    assign tx_flit   = make_flit(tx_dst_x, tx_dst_y, MY_X, MY_Y, tx_data);

    yc_noc_fifo #(.W(FLIT_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tx_push),
        .push_data (tx_flit),
        .pop       (tx_pop),
        .head      (inj_flit),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    assign ej_f     = flit_t'(ej_flit);
    assign ej_ready = rst_n && !rx_full;
    assign ej_take  = ej_valid && ej_ready;
    assign addr_ok  = (get_dst_x(ej_f) == MY_X) && (get_dst_y(ej_f) == MY_Y);
    assign rx_push  = ej_take && addr_ok;
    assign rx_entry = {get_src_x(ej_f), get_src_y(ej_f), get_payload(ej_f)};

    yc_noc_fifo #(.W(RX_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rx_push),
        .push_data (rx_entry),
        .pop       (rx_pop),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count)
    );

    assign rx_valid = rst_n && !rx_empty;
    assign rx_pop   = rx_valid && rx_ready;
    assign {rx_src_x, rx_src_y, rx_data} = rx_head;

    // Misaddressed flits are consumed and dropped; the counter saturates rather than wraps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            misroute_cnt <= '0;
            err_misroute <= 1'b0;
        end else if (ej_take && !addr_ok) begin
            if (misroute_cnt != 16'hFFFF) misroute_cnt <= misroute_cnt + 16'd1;
            err_misroute <= 1'b1;
        end
    end

endmodule

// File: tb/tb_yc_noc_ni.sv
// Self-checking bench for yc_noc_ni at node (1,1): directed vectors plus a random run
// against a queue-based reference model.
module tb_yc_noc_ni;
    import yc_noc_defs::*;

    localparam int X_ID = 1;
    localparam int Y_ID = 1;
    localparam int RX_W = 2*COORD_W + PAYLOAD_W;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 tx_valid, tx_ready;
    logic [COORD_W-1:0]   tx_dst_x, tx_dst_y;
    logic [PAYLOAD_W-1:0] tx_data;
    logic                 inj_valid, inj_ready;
    logic [FLIT_W-1:0]    inj_flit;
    logic                 ej_valid, ej_ready;
    logic [FLIT_W-1:0]    ej_flit;
    logic                 rx_valid, rx_ready;
    logic [COORD_W-1:0]   rx_src_x, rx_src_y;
    logic [PAYLOAD_W-1:0] rx_data;
    logic [2:0]           tx_count, rx_count;
    logic [15:0]          misroute_cnt;
    logic                 err_misroute;

    always #5 clk = ~clk;

    yc_noc_ni #(.X_ID(X_ID), .Y_ID(Y_ID), .TX_DEPTH(4), .RX_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_dst_x(tx_dst_x), .tx_dst_y(tx_dst_y),
        .tx_data(tx_data), .inj_valid(inj_valid), .inj_flit(inj_flit), .inj_ready(inj_ready),
        .ej_valid(ej_valid), .ej_flit(ej_flit), .ej_ready(ej_ready),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_src_x(rx_src_x), .rx_src_y(rx_src_y),
        .rx_data(rx_data), .tx_count(tx_count), .rx_count(rx_count),
        .misroute_cnt(misroute_cnt), .err_misroute(err_misroute)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are checked near the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    typedef struct {
        logic [COORD_W-1:0]   dx, dy, sx, sy;
        logic [PAYLOAD_W-1:0] data;
        bit                   good;
    } ej_vec_t;

    ej_vec_t vecs[6];
    flit_t   txq[$];
    logic [RX_W-1:0] rxq[$];
    int      exp_mis;
    bit      exp_err;
    flit_t   f, first_f;
    logic [PAYLOAD_W-1:0] exp_d;
    bit      mtx_rdy, minj_v, mej_rdy, mrx_v;

    initial begin
        rst_n = 1'b0; tx_valid = 0; tx_dst_x = '0; tx_dst_y = '0; tx_data = '0;
        inj_ready = 0; ej_valid = 0; ej_flit = '0; rx_ready = 0;
        exp_mis = 0; exp_err = 0;

        // Reset state
        step(); settle();
        chk("rst_tx_ready", tx_ready, 0);
        chk("rst_ej_ready", ej_ready, 0);
        step();
        rst_n = 1'b1;
        settle();
        chk("post_rst_tx_ready", tx_ready, 1);
        chk("post_rst_ej_ready", ej_ready, 1);
        chk("post_rst_inj_valid", inj_valid, 0);
        chk("post_rst_rx_valid", rx_valid, 0);
        chk("post_rst_counts", {tx_count, rx_count}, 0);
        chk("post_rst_mis", {misroute_cnt, err_misroute}, 0);

        // Single injection
        tx_valid = 1; tx_dst_x = 2; tx_dst_y = 1; tx_data = 16'hA5; inj_ready = 1;
        settle();
        chk("single_tx_ready", tx_ready, 1);
        chk("single_inj_valid_n", inj_valid, 0);
        step();
        tx_valid = 0;
        settle();
        chk("single_inj_valid", inj_valid, 1);
        f.dst_x = 2; f.dst_y = 1; f.src_x = 1; f.src_y = 1; f.payload = 16'hA5;
        chk("single_inj_flit", inj_flit, f);
        chk("single_tx_count", tx_count, 1);
        step(); settle();
        chk("single_tx_count0", tx_count, 0);
        chk("single_inj_valid0", inj_valid, 0);

        // Injection back-pressure: 5 offers into a 4-deep FIFO
        inj_ready = 0;
        first_f.dst_x = 3; first_f.dst_y = 0; first_f.src_x = 1; first_f.src_y = 1;
        first_f.payload = 16'h100;
        for (int i = 0; i < 5; i++) begin
            tx_valid = 1; tx_dst_x = 3; tx_dst_y = 0; tx_data = 16'(16'h100 + i);
            settle();
            chk($sformatf("bp_tx_ready%0d", i), tx_ready, (i < 4));
            if (i > 0) chk($sformatf("bp_stable%0d", i), inj_flit, first_f);
            step();
        end
        tx_valid = 0;
        settle();
        chk("bp_tx_count", tx_count, 4);
        chk("bp_stable_end", inj_flit, first_f);
        inj_ready = 1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk($sformatf("bp_drain_v%0d", i), inj_valid, 1);
            f = flit_t'(inj_flit);
            chk($sformatf("bp_drain_d%0d", i), f.payload, 16'h100 + i);
            step();
        end
        settle();
        chk("bp_drained", inj_valid, 0);
        inj_ready = 0;

        // Table-driven ejections: good, misrouted, self-addressed
        vecs[0] = '{dx:1, dy:1, sx:0, sy:3, data:16'h3C,   good:1};
        vecs[1] = '{dx:2, dy:2, sx:0, sy:0, data:16'h55,   good:0};
        vecs[2] = '{dx:1, dy:1, sx:7, sy:7, data:16'hFFFF, good:1};
        vecs[3] = '{dx:1, dy:0, sx:1, sy:1, data:16'h11,   good:0};
        vecs[4] = '{dx:0, dy:1, sx:2, sy:5, data:16'h22,   good:0};
        vecs[5] = '{dx:1, dy:1, sx:1, sy:1, data:16'h77,   good:1};
        for (int i = 0; i < 6; i++) begin
            f.dst_x = vecs[i].dx; f.dst_y = vecs[i].dy; f.src_x = vecs[i].sx;
            f.src_y = vecs[i].sy; f.payload = vecs[i].data;
            ej_valid = 1; ej_flit = f; rx_ready = 0;
            settle();
            chk($sformatf("vec%0d_ej_ready", i), ej_ready, 1);
            step();
            ej_valid = 0;
            if (!vecs[i].good) begin exp_mis++; exp_err = 1; end
            settle();
            chk($sformatf("vec%0d_rx_valid", i), rx_valid, vecs[i].good);
            if (vecs[i].good)
                chk($sformatf("vec%0d_rx", i), {rx_src_x, rx_src_y, rx_data},
                    {vecs[i].sx, vecs[i].sy, vecs[i].data});
            chk($sformatf("vec%0d_mis", i), misroute_cnt, exp_mis);
            chk($sformatf("vec%0d_err", i), err_misroute, exp_err);
            rx_ready = 1;
            step();
            rx_ready = 0;
        end

        // Fill RX, then sustained push+pop at count 3
        for (int i = 0; i < 5; i++) begin
            f.dst_x = 1; f.dst_y = 1; f.src_x = 2; f.src_y = 3; f.payload = 16'(16'h200 + i);
            ej_valid = 1; ej_flit = f;
            settle();
            chk($sformatf("fill_ej_ready%0d", i), ej_ready, (i < 4));
            step();
        end
        ej_valid = 0;
        settle();
        chk("fill_rx_count", rx_count, 4);
        chk("fill_ej_ready_full", ej_ready, 0);
        rx_ready = 1;
        step();
        for (int k = 0; k < 6; k++) begin
            f.dst_x = 1; f.dst_y = 1; f.src_x = 2; f.src_y = 3; f.payload = 16'(16'h300 + k);
            ej_valid = 1; ej_flit = f;
            settle();
            exp_d = (k < 3) ? 16'(16'h201 + k) : 16'(16'h300 + k - 3);
            chk($sformatf("pp_count%0d", k), rx_count, 3);
            chk($sformatf("pp_ej_ready%0d", k), ej_ready, 1);
            chk($sformatf("pp_data%0d", k), rx_data, exp_d);
            step();
        end
        ej_valid = 0;
        repeat (3) step();
        settle();
        chk("pp_drained", rx_count, 0);
        rx_ready = 0;

        // Randomized run against the queue model
        for (int c = 0; c < 600; c++) begin
            tx_valid  = ($urandom_range(0, 3) != 0);
            tx_dst_x  = COORD_W'($urandom);
            tx_dst_y  = COORD_W'($urandom);
            tx_data   = PAYLOAD_W'($urandom);
            inj_ready = ($urandom_range(0, 2) != 0);
            ej_valid  = ($urandom_range(0, 3) != 0);
            f = flit_t'(FLIT_W'($urandom));
            if ($urandom_range(0, 9) < 7) begin f.dst_x = 1; f.dst_y = 1; end
            ej_flit   = f;
            rx_ready  = ($urandom_range(0, 2) != 0);
            settle();
            mtx_rdy = txq.size() < 4;  minj_v = txq.size() > 0;
            mej_rdy = rxq.size() < 4;  mrx_v  = rxq.size() > 0;
            chk("rnd_tx_ready", tx_ready, mtx_rdy);
            chk("rnd_inj_valid", inj_valid, minj_v);
            if (minj_v) chk("rnd_inj_flit", inj_flit, txq[0]);
            chk("rnd_ej_ready", ej_ready, mej_rdy);
            chk("rnd_rx_valid", rx_valid, mrx_v);
            if (mrx_v) chk("rnd_rx", {rx_src_x, rx_src_y, rx_data}, rxq[0]);
            chk("rnd_counts", {tx_count, rx_count}, {3'(txq.size()), 3'(rxq.size())});
            chk("rnd_mis", {misroute_cnt, err_misroute}, {16'(exp_mis), exp_err});
            if (tx_valid && mtx_rdy) begin
                first_f.dst_x = tx_dst_x; first_f.dst_y = tx_dst_y;
                first_f.src_x = 1; first_f.src_y = 1; first_f.payload = tx_data;
                txq.push_back(first_f);
            end
            if (inj_ready && minj_v) void'(txq.pop_front());
            if (ej_valid && mej_rdy) begin
                if (f.dst_x == 1 && f.dst_y == 1) rxq.push_back({f.src_x, f.src_y, f.payload});
                else begin
                    if (exp_mis < 16'hFFFF) exp_mis++;
                    exp_err = 1;
                end
            end
            if (rx_ready && mrx_v) void'(rxq.pop_front());
            step();
        end
        tx_valid = 0; ej_valid = 0; inj_ready = 1; rx_ready = 1;
        repeat (5) step();
        txq.delete(); rxq.delete();
        settle();
        chk("rnd_drained", {tx_count, rx_count}, 0);

        // Misroute counter saturation
        f.dst_x = 2; f.dst_y = 2; f.src_x = 0; f.src_y = 0; f.payload = 16'h0;
        ej_valid = 1; ej_flit = f;
        for (int n = 0; n < 65536; n++) step();
        ej_valid = 0;
        settle();
        chk("sat_mis", misroute_cnt, 16'hFFFF);
        chk("sat_err", err_misroute, 1);
        chk("sat_rx_valid", rx_valid, 0);

        // Reset mid-operation with both FIFOs partially full
        inj_ready = 0; rx_ready = 0;
        tx_valid = 1; tx_dst_x = 0; tx_dst_y = 0; tx_data = 16'h9;
        f.dst_x = 1; f.dst_y = 1; f.payload = 16'h8;
        ej_valid = 1; ej_flit = f;
        repeat (2) step();
        tx_valid = 0; ej_valid = 0;
        settle();
        chk("mid_pre_counts", {tx_count, rx_count}, {3'd2, 3'd2});
        step();
        rst_n = 0;
        settle();
        chk("mid_rst_ready", {tx_ready, ej_ready}, 0);
        step();
        rst_n = 1;
        settle();
        chk("mid_inj_valid", inj_valid, 0);
        chk("mid_rx_valid", rx_valid, 0);
        chk("mid_counts", {tx_count, rx_count}, 0);
        chk("mid_mis", {misroute_cnt, err_misroute}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
